mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU core's external memory port. It accepts data reads, data writes and 32-bit instruction fetches, and serves them from a variable-latency 16-bit backing memory port (SRAM/SDRAM controller). It returns `e_mem_cack`, `e_mem_busy`, `e_mem_ready`, `e_mem_bus` and `e_sdram_instr` to the core. It sits between the core and the backing memory controller.

## Interface

Parameters:

- `BACK_AW`, 18: backing word-address width.
- `IBASE`, 18'h20000: backing base address of the instruction region.

Ports:

- `clk`  in  1: single clock. One clock only; every flop is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `e_addr_bus`  in  16: word address for data accesses; instruction index for fetches.
- `e_data`  in  16: write data.
- `ram_read`  in  1: read request, level.
- `ram_write`  in  1: write request, level.
- `ram_instr_access`  in  1: qualifies `ram_read` as an instruction fetch.
- `ram_read_done`  in  1: core has consumed read data.
- `e_mem_bus`  out  16: data read result.
- `e_sdram_instr`  out  32: instruction fetch result.
- `e_mem_cack`  out  1: command acknowledge, 1-cycle pulse.
- `e_mem_busy`  out  1: access in progress.
- `e_mem_ready`  out  1: access complete / read data valid.
- `back_req`  out  1: backing request, held until `back_ack`.
- `back_we`  out  1: backing write.
- `back_addr`  out  BACK_AW: backing address.
- `back_wdata`  out  16: backing write data.
- `back_ack`  in  1: write accepted, or `back_rdata` valid this cycle.
- `back_rdata`  in  16: backing read data.

## Operation

**States:** IDLE, DRD, DWR, IF_LO, IF_HI, RHOLD, WDONE.

**Address mapping** (all sums wrap modulo 2^BACK_AW):
- Data access: `back_addr = {2'b00, addr}`.
- Fetch of index k: low half at `IBASE + 2k`, high half at `IBASE + 2k + 1`.
- Result: `e_sdram_instr = {hi, lo}`.

**Acceptance (IDLE only):**
- A request is accepted only when the `armed` flag is set.
- `armed` is cleared on acceptance.
- `armed` is set in any cycle where `ram_read` and `ram_write` are both low.
- `armed` resets to 1.
- Address, write data and request type are latched at acceptance.
- `ram_write` has priority over `ram_read` when both are high.
- `ram_instr_access` is ignored for writes.

**Transitions:**
- Accepted write → DWR; data read → DRD; fetch → IF_LO.
- DRD: on `back_ack`, capture `back_rdata` into `e_mem_bus`, go to RHOLD.
- IF_LO: on `back_ack`, capture low half, go to IF_HI.
- IF_HI: on `back_ack`, capture high half, go to RHOLD.
- DWR: on `back_ack`, go to WDONE.
- WDONE: one cycle, then IDLE.
- RHOLD: stay until `ram_read_done=1` or `ram_read=0`, then IDLE.

**Outputs:**
- `e_mem_cack` = 1 in the first cycle of DRD, DWR or IF_LO.
- `e_mem_busy` = 1 in DRD, DWR, IF_LO, IF_HI.
- `e_mem_ready` = 1 in RHOLD and WDONE.
- `back_req` = 1 in DRD, DWR, IF_LO, IF_HI; `back_we` = 1 only in DWR.
- `e_mem_bus` and `e_sdram_instr` hold their last captured value until overwritten.

**Boundary conditions:**
- `back_ack` outside a requesting state is ignored.
- A request held high across completion is not re-served; the core must drop it first (`armed`).
- Requests arriving while not in IDLE are ignored; no queueing.
- Instruction index 0xFFFF maps to `IBASE+0x1FFFE` and `IBASE+0x1FFFF`; no carry into other bits is required.

## Timing

- **Reset:** all outputs 0, state IDLE, `armed`=1.
  - Reset mid-access drops `back_req` on the next edge.
  - The partial fetch is discarded.
- **Request seen in IDLE at cycle 0:**
  - `e_mem_cack`, `e_mem_busy` and `back_req` go high at cycle 1.
- **Data read, `back_ack` at cycle A:**
  - `e_mem_ready` high and `e_mem_busy` low at A+1.
  - The earliest ready is cycle 2 (ack in cycle 1).
- **Fetch:**
  - Low-half ack at cycle A; high-half request at A+1.
  - High-half ack at B; ready at B+1.
  - The earliest ready is cycle 3.
- **Write:**
  - `back_ack` at A gives `e_mem_ready` for exactly one cycle at A+1.
  - Back in IDLE at A+2.
- **Read release:**
  - `ram_read_done` seen at cycle R gives ready low at R+1.
  - The earliest new acceptance is at R+1, only if `armed`.
- **Backing port:** `back_addr`, `back_we` and `back_wdata` are stable for the whole `back_req` interval.

## Structure

- Shared package `mem_resp_pkg` holds:
  - the state encoding;
  - `BACK_AW` default;
  - `IBASE` default;
  - the request-type constants (DATA_RD, DATA_WR, IFETCH).
- No sub-module: a single FSM with a latched-request register and output registers.

## Test plan

- **Data read:** read `e_addr_bus`=0x1234, backing acks 3 cycles after `back_req` with 0xBEEF.
  - `back_addr`=0x01234.
  - `e_mem_cack` pulses once.
  - `e_mem_bus`=0xBEEF with ready the cycle after ack.
  - Ready drops the cycle after `ram_read_done`.
- **Instruction fetch:** fetch index 0x0010 with immediate acks returning 0x1111 then 0x2222.
  - `back_addr` = 0x20020 then 0x20021.
  - `e_sdram_instr`=0x22221111; ready at cycle 3.
- **Data write:** write 0xA5A5 to 0x00FF.
  - `back_we`=1, `back_addr`=0x000FF, `back_wdata`=0xA5A5.
  - Ready pulses exactly 1 cycle.
  - Holding `ram_write` high for 10 more cycles produces no second `back_req`.
- **Simultaneous read and write:** `ram_read` and `ram_write` both high at 0x0042.
  - A write is issued; no read reaches the backing port.
- **Reset mid-fetch:** assert `rst` between the low-half ack and the high-half ack.
  - All outputs 0 next cycle.
  - `ram_read` still high is accepted again immediately after reset as a fresh fetch starting at the low half.
- **Wrap-around:** fetch index 0xFFFF with `IBASE`=0x20000.
  - Addresses 0x3FFFE and 0x3FFFF.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory responder: FSM state encoding,
// backing-port defaults and the request kinds decoded at acceptance.
package mem_resp_pkg;

  localparam int unsigned BACK_AW_DEF = 18;
  localparam logic [17:0] IBASE_DEF   = 18'h20000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRD,
    S_DWR,
    S_IF_LO,
    S_IF_HI,
    S_RHOLD,
    S_WDONE
  } state_e;

  typedef enum logic [1:0] {
    DATA_RD = 2'd0,
    DATA_WR = 2'd1,
    IFETCH  = 2'd2
  } req_e;

  // A write wins over a simultaneous read, and the instruction qualifier
  // only ever applies to reads.
  function automatic req_e decode_req(input logic write, input logic instr);
    if (write) return DATA_WR;
    if (instr) return IFETCH;
    return DATA_RD;
  endfunction

endpackage

// File: rtl/mem_responder.sv
// Serves core data reads/writes and 32-bit instruction fetches from a
// variable-latency 16-bit backing port; fetches take two backing reads.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned          BACK_AW = BACK_AW_DEF,
  parameter logic [BACK_AW-1:0]   IBASE   = BACK_AW'(IBASE_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        e_addr_bus,
  input  logic [15:0]        e_data,
  input  logic               ram_read,
  input  logic               ram_write,
  input  logic               ram_instr_access,
  input  logic               ram_read_done,
  output logic [15:0]        e_mem_bus,
  output logic [31:0]        e_sdram_instr,
  output logic               e_mem_cack,
  output logic               e_mem_busy,
  output logic               e_mem_ready,
  output logic               back_req,
  output logic               back_we,
  output logic [BACK_AW-1:0] back_addr,
  output logic [15:0]        back_wdata,
  input  logic               back_ack,
  input  logic [15:0]        back_rdata
);

  state_e               state_q, state_d;
  logic                 armed_q, armed_d;
  logic                 cack_q, cack_d;
  logic [BACK_AW-1:0]   addr_q, addr_d;
  logic [15:0]          wdata_q, wdata_d;
  logic [15:0]          bus_q, bus_d;
  logic [15:0]          lo_q, lo_d;
  logic [31:0]          instr_q, instr_d;

  logic [BACK_AW-1:0]   data_addr;
  logic [BACK_AW-1:0]   fetch_addr;

  // Fetch index k occupies two consecutive backing words; sums wrap at BACK_AW.
  assign data_addr  = BACK_AW'(e_addr_bus);
  assign fetch_addr = IBASE + BACK_AW'({e_addr_bus, 1'b0});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      armed_q <= 1'b1;
      cack_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bus_q   <= '0;
      lo_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cack_q  <= cack_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      bus_q   <= bus_d;
      lo_q    <= lo_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cack_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    bus_d   = bus_q;
    lo_d    = lo_q;
    instr_d = instr_q;

    // The core must drop both strobes before another request is served.
    if (!ram_read && !ram_write) armed_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (armed_q && (ram_read || ram_write)) begin
          armed_d = 1'b0;
          cack_d  = 1'b1;
          wdata_d = e_data;
          case (decode_req(ram_write, ram_instr_access))
            DATA_WR: begin
              state_d = S_DWR;
              addr_d  = data_addr;
            end
            IFETCH: begin
              state_d = S_IF_LO;
              addr_d  = fetch_addr;
            end
            default: begin
              state_d = S_DRD;
              addr_d  = data_addr;
            end
          endcase
        end
      end
      S_DRD: begin
        if (back_ack) begin
          bus_d   = back_rdata;
          state_d = S_RHOLD;
        end
      end
      S_IF_LO: begin
        if (back_ack) begin
          lo_d    = back_rdata;
          addr_d  = addr_q + BACK_AW'(1);
          state_d = S_IF_HI;
        end
      end
      S_IF_HI: begin
        if (back_ack) begin
          instr_d = {back_rdata, lo_q};
          state_d = S_RHOLD;
        end
      end
      S_DWR: begin
        if (back_ack) state_d = S_WDONE;
      end
      S_WDONE: state_d = S_IDLE;
      S_RHOLD: begin
        if (ram_read_done || !ram_read) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign back_req      = (state_q == S_DRD) || (state_q == S_DWR) ||
                         (state_q == S_IF_LO) || (state_q == S_IF_HI);
  assign e_mem_busy    = back_req;
  assign back_we       = (state_q == S_DWR);
  assign e_mem_ready   = (state_q == S_RHOLD) || (state_q == S_WDONE);
  assign e_mem_cack    = cack_q;
  assign back_addr     = addr_q;
  assign back_wdata    = wdata_q;
  assign e_mem_bus     = bus_q;
  assign e_sdram_instr = instr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder: a backing-memory responder with
// per-request latency plus a core-level memory model predicting every result.
module tb_mem_responder;

  localparam int          AW    = 18;
  localparam logic [17:0] IB    = 18'h20000;
  localparam int          AMASK = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   e_addr_bus = '0;
  logic [15:0]   e_data = '0;
  logic          ram_read = 1'b0;
  logic          ram_write = 1'b0;
  logic          ram_instr_access = 1'b0;
  logic          ram_read_done = 1'b0;
  logic [15:0]   e_mem_bus;
  logic [31:0]   e_sdram_instr;
  logic          e_mem_cack;
  logic          e_mem_busy;
  logic          e_mem_ready;
  logic          back_req;
  logic          back_we;
  logic [AW-1:0] back_addr;
  logic [15:0]   back_wdata;
  logic          back_ack = 1'b0;
  logic [15:0]   back_rdata = '0;

  mem_responder #(.BACK_AW(AW), .IBASE(IB)) dut (
    .clk(clk), .rst(rst),
    .e_addr_bus(e_addr_bus), .e_data(e_data),
    .ram_read(ram_read), .ram_write(ram_write),
    .ram_instr_access(ram_instr_access), .ram_read_done(ram_read_done),
    .e_mem_bus(e_mem_bus), .e_sdram_instr(e_sdram_instr),
    .e_mem_cack(e_mem_cack), .e_mem_busy(e_mem_busy), .e_mem_ready(e_mem_ready),
    .back_req(back_req), .back_we(back_we), .back_addr(back_addr),
    .back_wdata(back_wdata), .back_ack(back_ack), .back_rdata(back_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Unwritten words read back as a fixed scramble of their address.
  function automatic logic [15:0] initVal(input int a);
    return 16'(a * 40503) ^ 16'h5A3C;
  endfunction

  logic [15:0] backMem [int];
  logic [15:0] expMem  [int];
  int          latQ[$];
  logic [34:0] backLog[$];
  bit          inReq = 1'b0;
  int          waitCnt = 0;
  logic [34:0] curReq = '0;

  function automatic logic [15:0] expRead(input int a);
    return expMem.exists(a) ? expMem[a] : initVal(a);
  endfunction

  // Backing memory: logs each new request, holds it for its latency, then acks.
  // With no request pending it sometimes raises a stray ack that must be ignored.
  always @(posedge clk) begin
    #2;
    back_ack = 1'b0;
    if (rst || !back_req) inReq = 1'b0;
    if (!rst && back_req) begin
      if (!inReq) begin
        inReq   = 1'b1;
        curReq  = {back_we, back_addr, back_wdata};
        backLog.push_back(curReq);
        waitCnt = (latQ.size() > 0) ? latQ.pop_front() : 0;
      end else begin
        checkOutput("backStable", 64'({back_we, back_addr, back_wdata}), 64'(curReq));
      end
      if (waitCnt == 0) begin
        int a;
        a        = int'(back_addr);
        back_ack = 1'b1;
        inReq    = 1'b0;
        if (back_we) backMem[a] = back_wdata;
        else back_rdata = backMem.exists(a) ? backMem[a] : initVal(a);
      end else begin
        waitCnt--;
      end
    end else if ($urandom_range(0, 3) == 0) begin
      back_ack   = 1'b1;
      back_rdata = 16'($urandom);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] expBus   = '0;
  logic [31:0] expInstr = '0;

  // kind: 0 data read, 1 data write, 2 instruction fetch.
  task automatic applyStimulus(input int kind, input logic [15:0] addr, input logic [15:0] data,
                               input int latA, input int latB, input bit both,
                               input int hold, input bit useDone);
    int          expAddr[$];
    bit          expWe[$];
    int          n;
    int          cnt;
    int          cackCnt;
    int          expReady;
    int          lo;
    int          hi;
    logic [34:0] ent;
    backLog.delete();
    latQ.delete();
    latQ.push_back(latA);
    latQ.push_back(latB);
    case (kind)
      0: begin
        expAddr.push_back(int'(addr)); expWe.push_back(1'b0);
        expBus   = expRead(int'(addr));
        expReady = 2 + latA;
      end
      1: begin
        expAddr.push_back(int'(addr)); expWe.push_back(1'b1);
        expMem[int'(addr)] = data;
        expReady = 2 + latA;
      end
      default: begin
        lo = (int'(IB) + 2 * int'(addr)) & AMASK;
        hi = (lo + 1) & AMASK;
        expAddr.push_back(lo); expWe.push_back(1'b0);
        expAddr.push_back(hi); expWe.push_back(1'b0);
        expInstr = {expRead(hi), expRead(lo)};
        expReady = 3 + latA + latB;
      end
    endcase

    e_addr_bus       = addr;
    e_data           = data;
    ram_write        = (kind == 1);
    ram_read         = (kind != 1) || both;
    ram_instr_access = (kind == 2) || ((kind == 1) && ($urandom_range(0, 1) == 1));
    tick();
    checkOutput("cack1", 64'(e_mem_cack), 64'(1));
    checkOutput("busy1", 64'(e_mem_busy), 64'(1));
    checkOutput("req1", 64'(back_req), 64'(1));
    e_addr_bus = 16'($urandom);
    e_data     = 16'($urandom);
    cackCnt = 1;
    n = 1;
    while (!e_mem_ready && n < 60) begin
      tick();
      n++;
      cackCnt += int'(e_mem_cack);
    end
    checkOutput("readyCycle", 64'(n), 64'(expReady));
    checkOutput("cackOnce", 64'(cackCnt), 64'(1));
    checkOutput("busyAtReady", 64'(e_mem_busy), 64'(0));
    checkOutput("backCount", 64'(backLog.size()), 64'(expAddr.size()));
    for (int i = 0; i < backLog.size() && i < expAddr.size(); i++) begin
      ent = backLog[i];
      checkOutput("backAddr", 64'(ent[33:16]), 64'(expAddr[i]));
      checkOutput("backWe", 64'(ent[34]), 64'(expWe[i]));
      if (expWe[i]) checkOutput("backWdata", 64'(ent[15:0]), 64'(data));
    end

    if (kind == 1) begin
      tick();
      checkOutput("wrPulse", 64'(e_mem_ready), 64'(0));
      cnt = 0;
      repeat (hold) begin
        tick();
        cnt += int'(back_req);
      end
      checkOutput("noReServe", 64'(cnt), 64'(0));
      ram_write = 1'b0; ram_read = 1'b0; ram_instr_access = 1'b0;
      tick();
    end else begin
      checkOutput("memBus", 64'(e_mem_bus), 64'(expBus));
      checkOutput("instr", 64'(e_sdram_instr), 64'(expInstr));
      cnt = 0;
      repeat (hold) begin
        tick();
        cnt += int'(e_mem_ready);
      end
      checkOutput("readyHeld", 64'(cnt), 64'(hold));
      checkOutput("busHeld", 64'(e_mem_bus), 64'(expBus));
      if (useDone) begin
        ram_read_done = 1'b1;
        tick();
        checkOutput("doneRelease", 64'(e_mem_ready), 64'(0));
        checkOutput("noReAccept", 64'(e_mem_busy), 64'(0));
        ram_read_done = 1'b0; ram_read = 1'b0; ram_instr_access = 1'b0;
        tick();
      end else begin
        ram_read = 1'b0; ram_instr_access = 1'b0;
        tick();
        checkOutput("dropRelease", 64'(e_mem_ready), 64'(0));
      end
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Ctl"}, 64'({e_mem_cack, e_mem_busy, e_mem_ready, back_req, back_we}), 64'(0));
    checkOutput({tag, "Addr"}, 64'(back_addr), 64'(0));
    checkOutput({tag, "Wdata"}, 64'(back_wdata), 64'(0));
    checkOutput({tag, "Bus"}, 64'(e_mem_bus), 64'(0));
    checkOutput({tag, "Instr"}, 64'(e_sdram_instr), 64'(0));
  endtask

  initial begin
    int kind;
    rst = 1'b1;
    repeat (3) tick();
    checkAllZero("reset");
    rst = 1'b0;
    tick();
    checkOutput("idleAfterReset", 64'(e_mem_busy), 64'(0));

    backMem[32'h1234] = 16'hBEEF; expMem[32'h1234] = 16'hBEEF;
    applyStimulus(0, 16'h1234, 16'h0000, 3, 0, 1'b0, 2, 1'b1);

    backMem[32'h20020] = 16'h1111; expMem[32'h20020] = 16'h1111;
    backMem[32'h20021] = 16'h2222; expMem[32'h20021] = 16'h2222;
    applyStimulus(2, 16'h0010, 16'h0000, 0, 0, 1'b0, 0, 1'b0);
    checkOutput("fetchPlan", 64'(e_sdram_instr), 64'(32'h22221111));

    applyStimulus(1, 16'h00FF, 16'hA5A5, 2, 0, 1'b0, 10, 1'b0);
    applyStimulus(0, 16'h00FF, 16'h0000, 1, 0, 1'b0, 1, 1'b0);
    checkOutput("readBackPlan", 64'(e_mem_bus), 64'(16'hA5A5));

    applyStimulus(1, 16'h0042, 16'h5C3A, 1, 0, 1'b1, 3, 1'b0);

    // Reset lands between the low-half ack and the delayed high-half ack.
    latQ.delete(); latQ.push_back(0); latQ.push_back(5);
    backLog.delete();
    e_addr_bus = 16'h0040; ram_read = 1'b1; ram_instr_access = 1'b1;
    tick();
    tick();
    checkOutput("hiHalfAddr", 64'(back_addr), 64'(32'h20081));
    rst = 1'b1;
    tick();
    checkAllZero("midFetchReset");
    rst = 1'b0;
    expBus = '0;
    expInstr = '0;
    applyStimulus(2, 16'h0040, 16'h0000, 1, 2, 1'b0, 1, 1'b1);

    applyStimulus(2, 16'hFFFF, 16'h0000, 1, 2, 1'b0, 0, 1'b0);

    for (int t = 0; t < 150; t++) begin
      kind = $urandom_range(0, 2);
      applyStimulus(kind,
                    (kind == 2) ? 16'($urandom) : 16'($urandom_range(0, 31)),
                    16'($urandom),
                    $urandom_range(0, 4), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
